// File: rtl/ctrl_irrigacao.sv
// rtl/ctrl_irrigacao.sv - irrigation cycle controller (valve/pump sequencing with low-tank alarm)
//
// Purpose:
//   Runs one irrigation cycle per request. The valve opens first, then the
//   pump runs, then the pump stops while the valve stays open, then a
//   forced pause follows. A low tank level aborts into an alarm state.
//
// Parameters (each 0..255, counted in ticks):
//   T_ABRE   valve-only time before pump start and after pump stop
//   T_ASP    sprinkler pumping time
//   T_GOT    drip pumping time
//   T_PAUSA  forced idle time after each cycle
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   tick         one-clk-wide time-base enable
//   Asp, Got     sprinkler / drip requests
//   nivel_baixo  tank-low sensor, active-high
//   Vasp, Vgot   sprinkler / drip valve drives
//   Bomba        pump drive
//   Ativo        cycle in progress
//   Alarme       low-tank alarm
//
// Configuration macro:
//   CTRL_IRRIGACAO_ALARME_TRAVA_EN  defined: alarm is latched until reset.
//                                   undefined: alarm clears once nivel_baixo,
//                                   Asp and Got are all low.

module ctrl_irrigacao #(
    parameter int unsigned T_ABRE  = 3,
    parameter int unsigned T_ASP   = 20,
    parameter int unsigned T_GOT   = 60,
    parameter int unsigned T_PAUSA = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic Asp,
    input  logic Got,
    input  logic nivel_baixo,
    output logic Vasp,
    output logic Vgot,
    output logic Bomba,
    output logic Ativo,
    output logic Alarme
);

    localparam logic [7:0] C_ABRE  = T_ABRE[7:0];
    localparam logic [7:0] C_ASP   = T_ASP[7:0];
    localparam logic [7:0] C_GOT   = T_GOT[7:0];
    localparam logic [7:0] C_PAUSA = T_PAUSA[7:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABRE,
        S_REGA,
        S_FECHA,
        S_PAUSA,
        S_ALARME
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       mode_got;   // 0 = sprinkler, 1 = drip; latched only in IDLE

    // The request that started the cycle; dropping it ends pumping early.
    logic req_held;
    assign req_held = mode_got ? Got : Asp;

    logic cnt_zero;
    assign cnt_zero = (cnt == 8'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= 8'd0;
            mode_got <= 1'b0;
        end else if (state != S_ALARME && nivel_baixo) begin
            // Low tank beats every other transition, IDLE included.
            state <= S_ALARME;
            cnt   <= 8'd0;
        end else begin
            // Loads on state entry take precedence over a coincident tick,
            // so a freshly loaded value is never decremented on its entry edge.
            case (state)
                S_IDLE: begin
                    if (Asp ^ Got) begin
                        mode_got <= Got;
                        state    <= S_ABRE;
                        cnt      <= C_ABRE;
                    end
                end
                S_ABRE: begin
                    if (cnt_zero) begin
                        state <= S_REGA;
                        cnt   <= mode_got ? C_GOT : C_ASP;
                    end else if (tick) begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_REGA: begin
                    if (cnt_zero || !req_held) begin
                        state <= S_FECHA;
                        cnt   <= C_ABRE;
                    end else if (tick) begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_FECHA: begin
                    if (cnt_zero) begin
                        state <= S_PAUSA;
                        cnt   <= C_PAUSA;
                    end else if (tick) begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_PAUSA: begin
                    if (cnt_zero) begin
                        state <= S_IDLE;
                    end else if (tick) begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_ALARME: begin
`ifdef CTRL_IRRIGACAO_ALARME_TRAVA_EN
                    state <= S_ALARME;
`else
                    if (!nivel_baixo && !Asp && !Got) begin
                        state <= S_IDLE;
                    end
`endif
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

    // Moore decode from registered state and mode.
    logic valve_open;
    assign valve_open = (state == S_ABRE) || (state == S_REGA) || (state == S_FECHA);

    assign Vasp   = valve_open & ~mode_got;
    assign Vgot   = valve_open &  mode_got;
    assign Bomba  = (state == S_REGA);
    assign Ativo  = valve_open || (state == S_PAUSA);
    assign Alarme = (state == S_ALARME);

endmodule

// File: doc/ctrl_irrigacao.md
CTRL_IRRIGACAO -- requirements
Module: ctrl_irrigacao

Interface
REQ-001 SHALL have parameter T_ABRE, default 3, ticks the valve stays open before pump start and after pump stop.
REQ-002 SHALL have parameter T_ASP, default 20, sprinkler pumping duration in ticks.
REQ-003 SHALL have parameter T_GOT, default 60, drip pumping duration in ticks.
REQ-004 SHALL have parameter T_PAUSA, default 10, ticks of forced idle after each cycle; every parameter value lies in 0..255.
REQ-005 SHALL have port clk  input  1  system clock; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port tick  input  1  one-clk-wide time-base enable pulse.
REQ-008 SHALL have port Asp  input  1  sprinkler request from the irrigation-type FSM.
REQ-009 SHALL have port Got  input  1  drip request from the irrigation-type FSM.
REQ-010 SHALL have port nivel_baixo  input  1  tank-low sensor, active-high.
REQ-011 SHALL have ports Vasp, Vgot, Bomba  output  1 each  sprinkler valve, drip valve and pump drives.
REQ-012 SHALL have ports Ativo, Alarme  output  1 each  cycle-in-progress and low-tank alarm flags.

Function
REQ-013 SHALL implement states IDLE, ABRE, REGA, FECHA, PAUSA and ALARME, with Moore outputs decoded from registered state and a registered mode bit.
REQ-014 SHALL keep an 8-bit down-counter loaded with the new state's parameter on entry to ABRE, REGA, FECHA or PAUSA, decremented on tick while nonzero, and held at zero.
REQ-015 SHALL leave ABRE, REGA, FECHA or PAUSA on the clk edge where the counter is zero, so parameter 0 gives a one-clk dwell.
REQ-016 IDLE: exactly one of Asp/Got high -> latch mode (Asp=sprinkler, Got=drip) and enter ABRE on the next edge; both high or both low -> stay IDLE.
REQ-017 Transitions: ABRE->REGA (counter loaded with T_ASP or T_GOT per mode), REGA->FECHA, FECHA->PAUSA, PAUSA->IDLE.
REQ-018 In REGA, the latched request input going low SHALL force FECHA on the next edge (early stop).
REQ-019 Asp/Got changes outside IDLE, other than the REQ-018 early stop, SHALL be ignored; mode never changes mid-cycle.
REQ-020 Vasp/Vgot SHALL be (mode match) AND state in {ABRE, REGA, FECHA}; never both high.
REQ-021 Bomba SHALL be high only in REGA.
REQ-022 Ativo SHALL be high in ABRE, REGA, FECHA and PAUSA.
REQ-023 Alarme SHALL be high only in ALARME, where Vasp, Vgot and Bomba are 0.
REQ-024 nivel_baixo high in any state other than ALARME SHALL enter ALARME on the next edge, with priority over all other transitions, including from IDLE.
REQ-025 tick coincident with a state entry SHALL not decrement the freshly loaded value.

Reset
REQ-026 reset SHALL be sampled only on the rising edge of clk.
REQ-027 reset SHALL have priority over every transition, including mid-cycle and ALARME.
REQ-028 Reset state SHALL be state IDLE, counter 0, mode sprinkler, and all outputs 0 on the first clk edge with reset high.

Configuration
REQ-029 Macro CTRL_IRRIGACAO_ALARME_TRAVA_EN defined: ALARME SHALL be exited only by reset.
REQ-030 Macro undefined: ALARME SHALL return to IDLE on the first edge where nivel_baixo, Asp and Got are all 0.

Verification
REQ-031 Defaults, tick every 4 clk, Asp pulse held high -> Vasp high 3 ticks, then Vasp+Bomba 20 ticks, then Vasp 3 ticks, then Ativo-only 10 ticks, then IDLE; Vgot 0 throughout.
REQ-032 Got held high, T_GOT=5 -> Vgot+Bomba for exactly 5 ticks; Vasp never 1.
REQ-033 Asp and Got both high in IDLE -> stays IDLE, all outputs 0.
REQ-034 Asp drops at tick 7 of REGA -> Bomba low on next clk, FECHA then PAUSA run their full durations.
REQ-035 nivel_baixo raised mid-REGA -> next clk Bomba=Vasp=0, Alarme=1; macro undefined: clears after nivel_baixo, Asp and Got are all 0; macro defined: held until reset.
REQ-036 reset asserted mid-FECHA -> next edge all outputs 0, state IDLE; all parameters 0 -> ABRE, REGA, FECHA and PAUSA each last exactly 1 clk.
